// File: rtl/keyed_mux_bank.sv
// Bank of NCH keyed multiplexers. Each channel picks one of 2^SEL_W candidate wires
// using a secret key loaded serially. Repeated malformed commits lock the block until reset.
module keyed_mux_bank #(
    parameter int NCH      = 2,
    parameter int SEL_W    = 2,
    parameter int MAX_FAIL = 3,
    localparam int KEY_W   = NCH * SEL_W,
    localparam int NCAND   = 1 << SEL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_si,
    input  logic                   key_shift,
    input  logic                   key_commit,
    input  logic [NCH*NCAND-1:0]   cand,
    output logic [NCH-1:0]         mux_o,
    output logic                   key_full,
    output logic                   key_valid,
    output logic                   locked
);

    localparam int CNT_W  = $clog2(KEY_W + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL, LOCKOUT} state_t;

    state_t              state;
    state_t              next_state;
    logic [KEY_W-1:0]    shift_reg;
    logic [KEY_W-1:0]    active_key;
    logic [CNT_W-1:0]    bit_cnt;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [FAIL_W-1:0]   fail_next;
    logic                do_shift;
    logic                do_commit;
    logic                do_fail;
    logic [NCH-1:0]      sel_bits;

    // Saturating increment so the counter can never wrap back below the lockout threshold.
    assign fail_next = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

    always_comb begin
        next_state = state;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        do_fail    = 1'b0;
        case (state)
            IDLE, SHIFT: begin
                if (key_commit) begin
                    do_fail    = 1'b1;
                    next_state = (fail_next == FAIL_W'(MAX_FAIL)) ? LOCKOUT : IDLE;
                end else if (key_shift) begin
                    do_shift   = 1'b1;
                    next_state = (bit_cnt == CNT_W'(KEY_W - 1)) ? FULL : SHIFT;
                end
            end
            FULL: begin
                if (key_commit) begin
                    do_commit  = 1'b1;
                    next_state = IDLE;
                end
            end
            LOCKOUT: next_state = LOCKOUT;
            default: next_state = IDLE;
        endcase
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [NCAND-1:0] cand_c;
        logic [SEL_W-1:0] key_c;
        assign cand_c      = cand[c*NCAND +: NCAND];
        assign key_c       = active_key[c*SEL_W +: SEL_W];
        assign sel_bits[c] = cand_c[key_c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            active_key <= '0;
            bit_cnt    <= '0;
            fail_cnt   <= '0;
            key_valid  <= 1'b0;
            mux_o      <= '0;
        end else begin
            state <= next_state;
            if (do_shift) begin
                shift_reg <= (shift_reg >> 1) | (KEY_W'(key_si) << (KEY_W - 1));
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (do_commit) begin
                active_key <= shift_reg;
                key_valid  <= 1'b1;
                bit_cnt    <= '0;
                fail_cnt   <= '0;
                shift_reg  <= '0;
            end
            if (do_fail) begin
                fail_cnt   <= fail_next;
                shift_reg  <= '0;
                bit_cnt    <= '0;
                active_key <= '0;
                key_valid  <= 1'b0;
            end
            // Uses the key in force before this edge, so a recommit switches cleanly one cycle later.
            mux_o <= (key_valid && next_state != LOCKOUT) ? sel_bits : '0;
        end
    end

    assign key_full = (state == FULL);
    assign locked   = (state == LOCKOUT);

endmodule

// File: tb/tb_keyed_mux_bank.sv
// Directed bench for keyed_mux_bank (NCH=2, SEL_W=2, MAX_FAIL=3) with a reference
// model feeding an expected-output queue that is drained after every clock edge.
module tb_keyed_mux_bank;

    localparam int S_IDLE  = 0;
    localparam int S_SHIFT = 1;
    localparam int S_FULL  = 2;
    localparam int S_LOCK  = 3;

    typedef struct packed {
        logic [1:0] mux;
        logic       full;
        logic       valid;
        logic       lock;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       key_si;
    logic       key_shift;
    logic       key_commit;
    logic [7:0] cand;
    logic [1:0] mux_o;
    logic       key_full;
    logic       key_valid;
    logic       locked;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];

    int         m_st;
    int         m_cnt;
    int         m_fail;
    logic [3:0] m_sr;
    logic [3:0] m_ak;
    logic       m_kv;

    keyed_mux_bank #(.NCH(2), .SEL_W(2), .MAX_FAIL(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_si     (key_si),
        .key_shift  (key_shift),
        .key_commit (key_commit),
        .cand       (cand),
        .mux_o      (mux_o),
        .key_full   (key_full),
        .key_valid  (key_valid),
        .locked     (locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = S_IDLE;
        m_cnt  = 0;
        m_fail = 0;
        m_sr   = '0;
        m_ak   = '0;
        m_kv   = 1'b0;
        sb.delete();
    endtask

    // One clock of stimulus: drive at the falling edge, predict, then compare 1 ns after the rising edge.
    task automatic step(input logic si, input logic sh, input logic cm, input logic [7:0] cv);
        logic [1:0] nmux;
        logic [3:0] sl;
        exp_t       e;
        @(negedge clk);
        rst        = 1'b0;
        key_si     = si;
        key_shift  = sh;
        key_commit = cm;
        cand       = cv;
        nmux = '0;
        if (m_kv) begin
            for (int c = 0; c < 2; c++) begin
                sl      = cv[c*4 +: 4];
                nmux[c] = sl[m_ak[c*2 +: 2]];
            end
        end
        case (m_st)
            S_IDLE, S_SHIFT: begin
                if (cm) begin
                    if (m_fail < 3) m_fail++;
                    m_sr  = '0;
                    m_cnt = 0;
                    m_ak  = '0;
                    m_kv  = 1'b0;
                    m_st  = (m_fail == 3) ? S_LOCK : S_IDLE;
                end else if (sh) begin
                    m_sr = {si, m_sr[3:1]};
                    m_cnt++;
                    m_st = (m_cnt == 4) ? S_FULL : S_SHIFT;
                end
            end
            S_FULL: begin
                if (cm) begin
                    m_ak   = m_sr;
                    m_kv   = 1'b1;
                    m_cnt  = 0;
                    m_fail = 0;
                    m_sr   = '0;
                    m_st   = S_IDLE;
                end
            end
            default: ;
        endcase
        if (m_st == S_LOCK) nmux = '0;
        e.mux   = nmux;
        e.full  = (m_st == S_FULL);
        e.valid = m_kv;
        e.lock  = (m_st == S_LOCK);
        sb.push_back(e);
        @(posedge clk);
        #1;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("[TB] FAIL sb_empty: got %0d expected %0d", sb.size(), 1);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("mux_o", 8'(mux_o), 8'(e.mux));
            check("key_full", 8'(key_full), 8'(e.full));
            check("key_valid", 8'(key_valid), 8'(e.valid));
            check("locked", 8'(locked), 8'(e.lock));
        end
    endtask

    task automatic shift_bits(input logic [3:0] bits, input int n, input logic [7:0] cv);
        for (int i = 0; i < n; i++) step(bits[i], 1'b1, 1'b0, cv);
    endtask

    // Reset raised between edges: outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_mux"}, 8'(mux_o), 8'd0);
        check({tag, "_full"}, 8'(key_full), 8'd0);
        check({tag, "_valid"}, 8'(key_valid), 8'd0);
        check({tag, "_locked"}, 8'(locked), 8'd0);
        model_reset();
    endtask

    initial begin
        rst        = 1'b1;
        key_si     = 1'b0;
        key_shift  = 1'b0;
        key_commit = 1'b0;
        cand       = 8'h00;
        model_reset();
        #1;
        check("rst_mux", 8'(mux_o), 8'd0);
        check("rst_full", 8'(key_full), 8'd0);
        check("rst_valid", 8'(key_valid), 8'd0);
        check("rst_locked", 8'(locked), 8'd0);

        // No key committed yet: output gated to zero regardless of candidates.
        step(1'b0, 1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 8'h42);
        step(1'b0, 1'b0, 1'b0, 8'hA5);
        check("gate_mux", 8'(mux_o), 8'd0);

        // Load 1,0,0,1 (first bit shifted first) and commit.
        shift_bits(4'b1001, 4, 8'h42);
        check("load_full", 8'(key_full), 8'd1);
        step(1'b0, 1'b0, 1'b1, 8'h42);
        check("commit_valid", 8'(key_valid), 8'd1);
        check("commit_mux0", 8'(mux_o), 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'h42);
        check("select_mux", 8'(mux_o), 8'h3);

        // One-cycle latency on candidate changes.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("latency_zero", 8'(mux_o), 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'h02);
        step(1'b0, 1'b0, 1'b0, 8'h42);

        // Recommit 0,1,1,0 while the old key stays active.
        shift_bits(4'b0110, 4, 8'h24);
        step(1'b0, 1'b0, 1'b1, 8'h24);
        check("recommit_old", 8'(mux_o), 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'h24);
        check("recommit_new", 8'(mux_o), 8'h3);

        // Overshift in FULL is ignored; shift+commit commits and drops the bit.
        shift_bits(4'b0011, 4, 8'h18);
        step(1'b1, 1'b1, 1'b0, 8'h18);
        check("overshift_full", 8'(key_full), 8'd1);
        step(1'b1, 1'b1, 1'b1, 8'h18);
        step(1'b0, 1'b0, 1'b0, 8'h18);
        check("priority_mux", 8'(mux_o), 8'h3);

        // Partial commit fails, then a full load succeeds and clears the fail count.
        shift_bits(4'b0011, 2, 8'h42);
        step(1'b0, 1'b0, 1'b1, 8'h42);
        check("partial_valid", 8'(key_valid), 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'h42);
        check("partial_mux", 8'(mux_o), 8'd0);
        shift_bits(4'b1001, 4, 8'h42);
        step(1'b0, 1'b0, 1'b1, 8'h42);
        step(1'b0, 1'b0, 1'b0, 8'h42);

        // Three partial commits lock the bank.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 8'h42);
            step(1'b0, 1'b0, 1'b1, 8'h42);
            if (k == 1) check("lock_not_yet", 8'(locked), 8'd0);
        end
        check("lock_set", 8'(locked), 8'd1);
        shift_bits(4'b1001, 4, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 8'hFF);
        check("lock_hold", 8'(locked), 8'd1);
        check("lock_mux", 8'(mux_o), 8'd0);

        // Reset clears lockout; a fresh load works again.
        async_reset("unlock");
        shift_bits(4'b1001, 4, 8'h42);
        step(1'b0, 1'b0, 1'b1, 8'h42);
        step(1'b0, 1'b0, 1'b0, 8'h42);
        check("unlock_mux", 8'(mux_o), 8'h3);

        // Reset mid-shift discards the partial key.
        shift_bits(4'b0110, 3, 8'h42);
        async_reset("midshift");
        shift_bits(4'b0110, 3, 8'h24);
        check("restart_not_full", 8'(key_full), 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'h24);
        check("restart_full", 8'(key_full), 8'd1);
        step(1'b0, 1'b0, 1'b1, 8'h24);
        step(1'b0, 1'b0, 1'b0, 8'h24);
        check("restart_mux", 8'(mux_o), 8'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
